dmem_arbiter: RTL and testbench

- Shares the single-port dmem between the processor (primary requester) and one peripheral port, such as the whack-a-mole input/score engine or a display reader.
- Sits between the processor's dmem pins and the dmem instance in the top-level skeleton.
- Processor has priority. A starvation counter guarantees the peripheral a slot by stalling the processor for one cycle.
- dmem is clocked on ~clock, so the address presented in cycle N returns mem_q before the rising edge that ends cycle N.

---
 rtl/dmem_pkg.sv | 9 +
 rtl/dmem_arbiter.sv | 63 ++++++
 tb/tb_dmem_arbiter.sv | 132 +++++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// dmem_pkg: shared dmem widths, arbiter state encoding and starvation default
package dmem_pkg;
  localparam int DMEM_ADDR_W = 12;
  localparam int DMEM_DATA_W = 32;
  localparam int DMEM_STARVE_LIMIT = 8;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] RESP = 2'd2;
endpackage

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares single-port dmem between cpu (priority) and one peripheral with a starvation-forced slot
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int ADDR_W = DMEM_ADDR_W,
  parameter int DATA_W = DMEM_DATA_W,
  parameter int STARVE_LIMIT = DMEM_STARVE_LIMIT
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_d,
  input  logic              cpu_wren,
  output logic [DATA_W-1:0] cpu_q,
  output logic              cpu_stall,
  input  logic              per_req,
  input  logic [ADDR_W-1:0] per_addr,
  input  logic [DATA_W-1:0] per_d,
  input  logic              per_wren,
  output logic              per_grant,
  output logic [DATA_W-1:0] per_q,
  output logic              per_valid,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_d,
  output logic              mem_wren,
  input  logic [DATA_W-1:0] mem_q
);
  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);
  logic [1:0] state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic grant;
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      rdata_q <= rdata_d;
    end
  end
  // reset masks the grant so no peripheral write slips through during reset
  always_comb begin
    grant = !reset && state_q != RESP && per_req && (!cpu_req || cnt_q == LIMIT);
    state_d = grant ? RESP : (state_q == RESP || !per_req) ? IDLE : WAIT;
    cnt_d = (grant || !per_req || state_q == RESP) ? '0 : (cnt_q == LIMIT) ? cnt_q : cnt_q + 1'b1;
    rdata_d = grant ? mem_q : rdata_q;
  end
  always_comb begin
    per_grant = grant;
    cpu_stall = grant && cpu_req;
    mem_addr = grant ? per_addr : cpu_addr;
    mem_d = grant ? per_d : cpu_d;
    mem_wren = grant ? per_wren : (cpu_wren && cpu_req && !reset);
    per_valid = state_q == RESP && !reset;
    per_q = rdata_q;
    cpu_q = mem_q;
  end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed vectors with a per_q scoreboard against a negedge dmem model
module tb_dmem_arbiter;
  import dmem_pkg::*;
  logic clk, reset;
  logic cpu_req, cpu_wren, cpu_stall;
  logic [11:0] cpu_addr, per_addr, mem_addr;
  logic [31:0] cpu_d, cpu_q, per_d, per_q, mem_d, mem_q;
  logic per_req, per_wren, per_grant, per_valid, mem_wren;
  logic [31:0] mem [0:4095];
  logic [31:0] exp_q [$];
  int errors = 0;
  int checks = 0;

  dmem_arbiter dut (
    .clock(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_d(cpu_d), .cpu_wren(cpu_wren),
    .cpu_q(cpu_q), .cpu_stall(cpu_stall),
    .per_req(per_req), .per_addr(per_addr), .per_d(per_d), .per_wren(per_wren),
    .per_grant(per_grant), .per_q(per_q), .per_valid(per_valid),
    .mem_addr(mem_addr), .mem_d(mem_d), .mem_wren(mem_wren), .mem_q(mem_q)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (mem_wren) mem[mem_addr] <= mem_d;
    mem_q <= mem_wren ? mem_d : mem[mem_addr];
  end

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  always @(posedge clk) begin
    #3;
    if (per_valid) begin
      if (exp_q.size() == 0) chk("unexpected_per_valid", 32'd1, 32'd0);
      else chk("per_q", per_q, exp_q.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1; cpu_req = 0; cpu_addr = 0; cpu_d = 0; cpu_wren = 0;
    per_req = 1; per_addr = 12'h010; per_wren = 1; per_d = 32'hDEADBEEF;
    repeat (3) begin
      cyc(); #1;
      chk("rst_grant", per_grant, 0);
      chk("rst_wren", mem_wren, 0);
      chk("rst_valid", per_valid, 0);
      chk("rst_stall", cpu_stall, 0);
    end
    cyc(); reset = 0; #1;
    chk("first_grant", per_grant, 1);
    chk("first_wren", mem_wren, 1);
    exp_q.push_back(32'hDEADBEEF);
    cyc(); per_req = 0; per_wren = 0; #1;
    chk("first_resp_grant", per_grant, 0);
    cyc();
    cyc(); per_req = 1; #1;
    chk("read_grant", per_grant, 1);
    chk("read_addr", mem_addr, 32'h010);
    exp_q.push_back(32'hDEADBEEF);
    cyc(); per_req = 0; #1;
    chk("read_valid", per_valid, 1);
    cyc(); #1;
    chk("read_valid_off", per_valid, 0);
    for (int i = 0; i < 9; i++) begin
      cyc(); cpu_req = 1; cpu_addr = 12'h030; per_req = 1; #1;
      chk("starve_grant", per_grant, i == 8);
      chk("starve_stall", cpu_stall, i == 8);
    end
    exp_q.push_back(32'hDEADBEEF);
    cyc(); per_req = 0; #1;
    chk("starve_release_stall", cpu_stall, 0);
    chk("starve_release_grant", per_grant, 0);
    for (int i = 0; i < 9; i++) begin
      cyc();
      cpu_req = 1; cpu_wren = 1; cpu_addr = 12'h020; cpu_d = 32'h1111;
      per_req = 1; per_wren = 1; per_addr = 12'h020; per_d = 32'h2222;
      #1;
      chk("conflict_grant", per_grant, i == 8);
    end
    #4;
    chk("conflict_mem", mem[12'h020], 32'h2222);
    exp_q.push_back(32'h2222);
    cyc(); per_req = 0; per_wren = 0; #1;
    chk("conflict_retry_stall", cpu_stall, 0);
    #4;
    chk("conflict_retry_mem", mem[12'h020], 32'h1111);
    cyc(); cpu_req = 0; cpu_wren = 0;
    for (int i = 0; i < 3; i++) begin
      cyc(); cpu_req = 1; cpu_addr = 12'h030; per_req = 1; #1;
      chk("wd_grant", per_grant, 0);
    end
    cyc(); per_req = 0; #1;
    chk("wd_drop_grant", per_grant, 0);
    cyc(); #1;
    chk("wd_state", 32'(dut.state_q), 32'(IDLE));
    chk("wd_cnt", 32'(dut.cnt_q), 0);
    for (int k = 0; k < 4; k++) begin
      cyc(); cpu_req = 0; cpu_wren = 0; per_req = 1; per_addr = 12'h010; #1;
      chk("b2b_grant", per_grant, 1);
      exp_q.push_back(32'hDEADBEEF);
      cyc(); cpu_req = 1; cpu_wren = 1; cpu_addr = 12'h040 + 12'(k); cpu_d = 32'h100 + 32'(k); #1;
      chk("b2b_resp_grant", per_grant, 0);
      chk("b2b_resp_stall", cpu_stall, 0);
      chk("b2b_cpu_wren", mem_wren, 1);
    end
    cyc(); per_req = 0; cpu_req = 0; cpu_wren = 0;
    cyc(); cyc();
    for (int k = 0; k < 4; k++) chk("b2b_cpu_mem", mem[12'h040 + 12'(k)], 32'h100 + 32'(k));
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
